// File: rtl/tcni_mem_responder.sv
// Word-addressed scratchpad responder for the TCNI NI memory port: req/ack handshake, masked writes.
// Optional macro TCNI_MEM_OUTREG_EN adds an RD2 stage that registers the array output (read latency 3).
module tcni_mem_responder #(
   parameter int          DEPTH     = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clock_in,
   input  logic        reset_in,
   input  logic        req_in,
   input  logic [31:0] addr_in,
   input  logic [31:0] data_in,
   input  logic [3:0]  wb_in,
   output logic [31:0] data_out,
   output logic        ack_out,
   output logic        err_out
);

   // state | meaning
   // IDLE  | waiting for req_in; writes commit here
   // RD    | synchronous array read of latched index
   // RD2   | array output register stage (TCNI_MEM_OUTREG_EN only)
   // ACK   | one-cycle ack_out pulse with err/data, then back to IDLE

   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RD   = 2'd1;
`ifdef TCNI_MEM_OUTREG_EN
   localparam logic [1:0] RD2  = 2'd2;
`endif
   localparam logic [1:0] ACK  = 2'd3;

   logic [1:0]    state;
   logic [31:0]   mem [DEPTH];
   logic [32:0]   offset;
   logic [AW-1:0] idx;
   logic          in_range;
   logic [AW-1:0] idx_q;
   logic          err_q;
   logic          accept;
   logic          wr_en;
   logic          unused_bits;

   // 33-bit subtraction so addresses below the base wrap to a large, out-of-range offset
   assign offset      = {1'b0, addr_in} - {1'b0, BASE_ADDR};
   assign idx         = offset[AW+1:2];
   assign in_range    = (offset[32:AW+2] == '0);
   assign unused_bits = ^offset[1:0];

   assign accept = !reset_in && (state == IDLE) && req_in;
   assign wr_en  = accept && (wb_in != 4'b0000) && in_range;

   always_ff @(posedge clock_in) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wb_in[b]) begin
               mem[idx][8*b +: 8] <= data_in[8*b +: 8];
            end
         end
      end
   end

`ifdef TCNI_MEM_OUTREG_EN
   logic [31:0] rd_q;

   always_ff @(posedge clock_in) begin
      if (state == RD) begin
         rd_q <= mem[idx_q];
      end
   end
`endif

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         state    <= IDLE;
         ack_out  <= 1'b0;
         err_out  <= 1'b0;
         data_out <= '0;
         idx_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ack_out  <= 1'b0;
               err_out  <= 1'b0;
               data_out <= '0;
               if (req_in) begin
                  if (wb_in != 4'b0000) begin
                     ack_out <= 1'b1;
                     err_out <= !in_range;
                     state   <= ACK;
                  end else begin
                     idx_q <= idx;
                     err_q <= !in_range;
                     state <= RD;
                  end
               end
            end
            RD: begin
`ifdef TCNI_MEM_OUTREG_EN
               state <= RD2;
`else
               ack_out  <= 1'b1;
               err_out  <= err_q;
               data_out <= err_q ? '0 : mem[idx_q];
               state    <= ACK;
`endif
            end
`ifdef TCNI_MEM_OUTREG_EN
            RD2: begin
               ack_out  <= 1'b1;
               err_out  <= err_q;
               data_out <= err_q ? '0 : rd_q;
               state    <= ACK;
            end
`endif
            ACK: begin
               ack_out  <= 1'b0;
               err_out  <= 1'b0;
               data_out <= '0;
               state    <= IDLE;
            end
            default: begin
               ack_out  <= 1'b0;
               err_out  <= 1'b0;
               data_out <= '0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule
